div_share_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one sequential divider (div) between N_REQ requesters.

---
 rtl/div_share_arbiter.sv | 121 ++++++++++++
 tb/tb_div_share_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// Round-robin sequencer sharing one sequential divider between N_REQ level requesters.
// Latency: request->o_div_start 2 cycles (divider ready); i_div_done->o_done 2 cycles; >=1 idle cycle between ops.
// Backpressure: waits in e_issue while i_div_ready is low; unserved requesters stay pending until granted.
//
// Ports: i_req/i_dividend/i_divisor (flat, requester k at [k*WIDTH +: WIDTH]) in;
//        o_gnt/o_done/o_quotient/o_remain/o_busy out to requesters;
//        o_div_start/o_div_dividend/o_div_divisor out, i_div_ready/i_div_done/i_div_quotient/i_div_remain in (divider side).
// Optional feature macro: DIV_ZERO_BYPASS_EN -- zero divisors are answered locally
// (quotient all ones, remainder = dividend) without starting the divider.
module div_share_arbiter #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_dividend,
    input  logic [N_REQ*WIDTH-1:0] i_divisor,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [N_REQ-1:0]       o_done,
    output logic [WIDTH-1:0]       o_quotient,
    output logic [WIDTH-1:0]       o_remain,
    output logic                   o_busy,
    output logic                   o_div_start,
    output logic [WIDTH-1:0]       o_div_dividend,
    output logic [WIDTH-1:0]       o_div_divisor,
    input  logic                   i_div_ready,
    input  logic                   i_div_done,
    input  logic [WIDTH-1:0]       i_div_quotient,
    input  logic [WIDTH-1:0]       i_div_remain
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {e_idle, e_issue, e_wait, e_respond} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_last;     // index served most recently; scan starts just after it
    logic [IW-1:0]   r_idx;      // index currently granted
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;

    // Round-robin scan r_last+1, r_last+2, ... (mod N_REQ); first pending request wins.
    always_comb begin : arb
        int k;
        k        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(r_last) + i) % N_REQ;
            if (!pick_vld && ((i_req & (N_REQ'(1) << k)) != '0)) begin
                pick_vld = 1'b1;
                pick_idx = IW'(k);
            end
        end
    end

    assign o_busy = (r_state != e_idle);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= e_idle;
            r_last         <= IW'(N_REQ - 1);
            r_idx          <= '0;
            o_gnt          <= '0;
            o_done         <= '0;
            o_quotient     <= '0;
            o_remain       <= '0;
            o_div_start    <= 1'b0;
            o_div_dividend <= '0;
            o_div_divisor  <= '0;
        end else begin
            o_div_start <= 1'b0;
            o_done      <= '0;
            case (r_state)
                e_idle: begin
                    if (o_done != '0) begin
                        // Done cycle: the served requester still holds i_req, so
                        // release the grant and arbitrate only from the next cycle.
                        o_gnt <= '0;
                    end else if (pick_vld) begin
                        o_gnt          <= N_REQ'(1) << pick_idx;
                        r_idx          <= pick_idx;
                        o_div_dividend <= WIDTH'(i_dividend >> (int'(pick_idx) * WIDTH));
                        o_div_divisor  <= WIDTH'(i_divisor >> (int'(pick_idx) * WIDTH));
                        r_state        <= e_issue;
                    end else begin
                        o_gnt <= '0;
                    end
                end
                e_issue: begin
`ifdef DIV_ZERO_BYPASS_EN
                    if (o_div_divisor == '0) begin
                        o_quotient <= '1;
                        o_remain   <= o_div_dividend;
                        r_state    <= e_respond;
                    end else
`endif
                    if (i_div_ready) begin
                        o_div_start <= 1'b1;
                        r_state     <= e_wait;
                    end
                end
                e_wait: begin
                    if (i_div_done) begin
                        o_quotient <= i_div_quotient;
                        o_remain   <= i_div_remain;
                        r_state    <= e_respond;
                    end
                end
                e_respond: begin
                    o_done  <= o_gnt;
                    r_last  <= r_idx;
                    r_state <= e_idle;
                end
                default: r_state <= e_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a small behavioural divider (3-cycle latency).
// Latency: n/a.
// Backpressure: divider ready can be held low from the stimulus via hold_low.
module tb_div_share_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req;
    logic [N*W-1:0] dvd;
    logic [N*W-1:0] dvs;
    logic [N-1:0]   o_gnt, o_done;
    logic [W-1:0]   o_quotient, o_remain;
    logic           o_busy, o_div_start;
    logic [W-1:0]   o_div_dividend, o_div_divisor;
    logic           i_div_ready    = 1'b0;
    logic           i_div_done     = 1'b0;
    logic [W-1:0]   i_div_quotient = '0;
    logic [W-1:0]   i_div_remain   = '0;

    logic           hold_low;
    int             checks;
    int             errors;
    int             starts = 0;
    int             onehot_bad;

    // divider model state
    logic           m_busy = 1'b0;
    int             m_cnt  = 0;
    logic [W-1:0]   m_a    = '0;
    logic [W-1:0]   m_b    = '0;

    div_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req          (i_req),
        .i_dividend     (dvd),
        .i_divisor      (dvs),
        .o_gnt          (o_gnt),
        .o_done         (o_done),
        .o_quotient     (o_quotient),
        .o_remain       (o_remain),
        .o_busy         (o_busy),
        .o_div_start    (o_div_start),
        .o_div_dividend (o_div_dividend),
        .o_div_divisor  (o_div_divisor),
        .i_div_ready    (i_div_ready),
        .i_div_done     (i_div_done),
        .i_div_quotient (i_div_quotient),
        .i_div_remain   (i_div_remain)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_div_start === 1'b1) starts++;

    // Divider model, updated on the falling edge so it never races the DUT.
    always @(negedge i_clk) begin
        if (i_rst) begin
            m_busy         = 1'b0;
            m_cnt          = 0;
            i_div_done     = 1'b0;
            i_div_quotient = '0;
            i_div_remain   = '0;
        end else begin
            i_div_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy         = 1'b0;
                    i_div_done     = 1'b1;
                    i_div_quotient = (m_b != 0) ? m_a / m_b : '1;
                    i_div_remain   = (m_b != 0) ? m_a % m_b : m_a;
                end
            end else if (o_div_start === 1'b1) begin
                m_a    = o_div_dividend;
                m_b    = o_div_divisor;
                m_busy = 1'b1;
                m_cnt  = 3;
            end
        end
        i_div_ready = !m_busy && !hold_low;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
        if ((o_gnt & (o_gnt - 1'b1)) != '0) onehot_bad++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp_done,
                             input logic [31:0] exp_q, input logic [31:0] exp_r);
        int n;
        n = 0;
        while (o_done == '0 && n < 200) begin
            step();
            n++;
        end
        check({tag, "_done"}, 32'(o_done), exp_done);
        check({tag, "_quot"}, o_quotient, exp_q);
        check({tag, "_rem"}, o_remain, exp_r);
    endtask

    initial begin
        int s0;
        int n;
        checks     = 0;
        errors     = 0;
        onehot_bad = 0;
        hold_low   = 1'b0;
        i_rst      = 1'b1;
        i_req      = '0;
        dvd        = '0;
        dvs        = '0;
        repeat (2) step();

        // reset state
        check("rst_gnt",   32'(o_gnt), 0);
        check("rst_done",  32'(o_done), 0);
        check("rst_busy",  32'(o_busy), 0);
        check("rst_start", 32'(o_div_start), 0);
        check("rst_quot",  o_quotient, 0);
        i_rst = 1'b0;
        step();

        // 1: single request, latency to start
        s0 = starts;
        dvd[31:0] = 32'd1_000_000_000;
        dvs[31:0] = 32'd1000;
        i_req = 2'b01;
        step();
        check("t1_gnt",    32'(o_gnt), 32'h1);
        check("t1_start0", 32'(o_div_start), 0);
        step();
        check("t1_start1", 32'(o_div_start), 1);
        wait_done("t1", 32'h1, 32'd1_000_000, 32'd0);
        i_req = '0;
        step();
        check("t1_gnt_clr", 32'(o_gnt), 0);
        check("t1_nstart",  32'(starts - s0), 1);
        step();

        // 2: simultaneous requests after reset, requester 0 first
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        dvd = {32'd50, 32'd100};
        dvs = {32'd3, 32'd7};
        i_req = 2'b11;
        wait_done("t2a", 32'h1, 32'd14, 32'd2);
        i_req = 2'b10;
        step();
        wait_done("t2b", 32'h2, 32'd16, 32'd2);
        i_req = '0;
        repeat (2) step();

        // 3: both held high for six operations -> strict alternation
        i_req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (o_done == '0 && n < 200) begin
                step();
                n++;
            end
            check($sformatf("t3_rr%0d", k), 32'(o_done), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
        end
        i_req = '0;
        repeat (4) step();
        check("onehot", 32'(onehot_bad), 0);

        // 4: zero divisor
        s0 = starts;
        dvd[31:0] = 32'd1234;
        dvs[31:0] = 32'd0;
        i_req = 2'b01;
        wait_done("t4", 32'h1, 32'hFFFF_FFFF, 32'd1234);
        i_req = '0;
`ifdef DIV_ZERO_BYPASS_EN
        check("t4_nstart", 32'(starts - s0), 0);
`else
        check("t4_nstart", 32'(starts - s0), 1);
`endif
        repeat (2) step();

        // 5: reset while waiting for the divider
        dvd[31:0] = 32'd1_000_000_000;
        dvs[31:0] = 32'd1000;
        i_req = 2'b01;
        n = 0;
        while (o_div_start !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        step();
        i_rst = 1'b1;
        #1;
        check("t5_gnt",  32'(o_gnt), 0);
        check("t5_busy", 32'(o_busy), 0);
        check("t5_quot", o_quotient, 0);
        i_req = '0;
        repeat (2) step();
        i_rst = 1'b0;
        n = 0;
        repeat (8) begin
            step();
            if (o_done != '0) n++;
        end
        check("t5_nodone", 32'(n), 0);
        dvd[31:0] = 32'd100;
        dvs[31:0] = 32'd7;
        i_req = 2'b01;
        wait_done("t5", 32'h1, 32'd14, 32'd2);
        i_req = '0;
        repeat (2) step();

        // 6: divider not ready for several cycles
        hold_low = 1'b1;
        repeat (2) step();
        s0 = starts;
        i_req = 2'b10;
        repeat (6) step();
        check("t6_held",  32'(starts - s0), 0);
        check("t6_busy",  32'(o_busy), 1);
        hold_low = 1'b0;
        wait_done("t6", 32'h2, 32'd16, 32'd2);
        i_req = '0;
        check("t6_nstart", 32'(starts - s0), 1);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
